// File: rtl/aes_pipe_ctrl_pkg.sv
// Shared definitions for the AES pipeline controller: block width, latency defaults,
// controller state encoding and the two-way round-robin pick function.
package aes_ctrl_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int PIPE_LAT_DEF = 10;
  localparam int KEY_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    KEYLOAD = 2'd3
  } ctrl_state_t;

  // last = index of the requester granted most recently; the other one wins a tie
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/aes_pipe_ctrl_rr_arb.sv
// Two-way round-robin arbiter (module aes_ctrl_rr_arb); the last-grant pointer only
// moves when the granted block is actually accepted.
module aes_ctrl_rr_arb
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last;

  assign o_grant = rr_pick(i_req, r_last);

  // Pointer resets to requester 1 so requester 0 takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_advance) begin
      r_last <= o_grant[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/aes_pipe_ctrl.sv
// AES pipeline front-end: key sequencing, two-requester arbitration and response tagging.
// Optional statistics counters are built when AES_PIPE_CTRL_STATS_EN is defined.
module aes_pipe_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int KEY_LAT  = KEY_LAT_DEF,
  parameter int TAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_data,
  input  logic [TAG_W-1:0]     req1_tag,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_BLK_W-1:0] key_in,
  output logic [AES_BLK_W-1:0] pipe_data,
  output logic [AES_BLK_W-1:0] pipe_key,
  input  logic [AES_BLK_W-1:0] pipe_out,
  output logic                 rsp_valid,
  output logic                 rsp_src,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [AES_BLK_W-1:0] rsp_data
`ifdef AES_PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_blocks,
  output logic [15:0]          stat_rekeys
`endif
);

  localparam int KCW = $clog2(KEY_LAT + 1);
  localparam int IFW = $clog2(PIPE_LAT + 1);

  ctrl_state_t          r_state;
  ctrl_state_t          w_state_nxt;
  logic [KCW-1:0]       r_kcnt;
  logic [IFW-1:0]       r_inflight;
  logic                 w_key_rdy;
  logic                 w_acc_en;
  logic                 w_key_hs;
  logic [1:0]           w_req;
  logic [1:0]           w_grant;
  logic                 w_acc;
  logic                 w_acc_src;
  logic [TAG_W-1:0]     w_acc_tag;
  logic [AES_BLK_W-1:0] w_acc_data;

  logic                 r_sr_vld [PIPE_LAT];
  logic                 r_sr_src [PIPE_LAT];
  logic [TAG_W-1:0]     r_sr_tag [PIPE_LAT];

  logic                 r_rsp_valid;
  logic                 r_rsp_src;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [AES_BLK_W-1:0] r_pipe_data;
  logic [AES_BLK_W-1:0] r_pipe_key;

  // Next-state and handshake enables; reset masks every ready in the reset cycle
  always_comb begin
    w_state_nxt = r_state;
    w_key_rdy   = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      NOKEY: begin
        w_key_rdy = 1'b1;
        if (key_valid) w_state_nxt = KEYLOAD;
        else           w_state_nxt = NOKEY;
      end
      RUN: begin
        if (key_valid) w_state_nxt = DRAIN;
        else           w_acc_en    = 1'b1;
      end
      DRAIN: begin
        w_key_rdy = (r_inflight == '0);
        if (key_valid && w_key_rdy) w_state_nxt = KEYLOAD;
        else                        w_state_nxt = DRAIN;
      end
      KEYLOAD: begin
        if (r_kcnt == KCW'(KEY_LAT - 1)) w_state_nxt = RUN;
        else                             w_state_nxt = KEYLOAD;
      end
      default: w_state_nxt = NOKEY;
    endcase
    if (rst) begin
      w_key_rdy = 1'b0;
      w_acc_en  = 1'b0;
    end else begin
      w_key_rdy = w_key_rdy;
      w_acc_en  = w_acc_en;
    end
  end

  assign w_key_hs   = key_valid & w_key_rdy;
  assign w_req      = {req1_valid, req0_valid} & {2{w_acc_en}};
  assign w_acc      = |w_grant;
  assign w_acc_src  = w_grant[1];
  assign w_acc_tag  = w_grant[1] ? req1_tag  : req0_tag;
  assign w_acc_data = w_grant[1] ? req1_data : req0_data;

  aes_ctrl_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_acc),
    .o_grant   (w_grant)
  );

  // Controller state and key-load cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NOKEY;
      r_kcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kcnt  <= (r_state == KEYLOAD) ? r_kcnt + KCW'(1) : '0;
    end
  end

  // Data and key registers feeding the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_data <= '0;
      r_pipe_key  <= '0;
    end else begin
      if (w_acc)    r_pipe_data <= w_acc_data;
      if (w_key_hs) r_pipe_key  <= key_in;
    end
  end

  // Source/tag shadow pipeline; the response register adds the final edge of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_sr_vld[i] <= 1'b0;
        r_sr_src[i] <= 1'b0;
        r_sr_tag[i] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      r_sr_vld[0] <= w_acc;
      r_sr_src[0] <= w_acc_src;
      r_sr_tag[0] <= w_acc_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_src[i] <= r_sr_src[i-1];
        r_sr_tag[i] <= r_sr_tag[i-1];
      end
      r_rsp_valid <= r_sr_vld[PIPE_LAT-1];
      r_rsp_src   <= r_sr_src[PIPE_LAT-1];
      r_rsp_tag   <= r_sr_tag[PIPE_LAT-1];
    end
  end

  // Blocks in flight, counted from acceptance until their response cycle ends
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_acc, r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifdef AES_PIPE_CTRL_STATS_EN
  logic [31:0] r_stat_blocks;
  logic [15:0] r_stat_rekeys;

  // Free-running event counters, wrapping at all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_blocks <= 32'd0;
      r_stat_rekeys <= 16'd0;
    end else begin
      if (w_acc)    r_stat_blocks <= r_stat_blocks + 32'd1;
      if (w_key_hs) r_stat_rekeys <= r_stat_rekeys + 16'd1;
    end
  end

  assign stat_blocks = r_stat_blocks;
  assign stat_rekeys = r_stat_rekeys;
`endif

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign key_ready  = w_key_rdy;
  assign pipe_data  = r_pipe_data;
  assign pipe_key   = r_pipe_key;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_src    = r_rsp_src;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_data   = pipe_out;

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Bench for aes_pipe_ctrl: an AES-128 pipeline model drives pipe_out, and a transaction-level
// model of the key/accept rules predicts every handshake and response.
module tb_aes_pipe_ctrl;

  localparam int PL = 10;
  localparam int KL = 10;
  localparam int TW = 4;

  logic           clk, rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0]   req0_data, req1_data;
  logic [TW-1:0]  req0_tag, req1_tag;
  logic           key_valid, key_ready;
  logic [127:0]   key_in, pipe_data, pipe_key, pipe_out, rsp_data;
  logic           rsp_valid, rsp_src;
  logic [TW-1:0]  rsp_tag;
`ifdef AES_PIPE_CTRL_STATS_EN
  logic [31:0]    stat_blocks;
  logic [15:0]    stat_rekeys;
`endif

  aes_pipe_ctrl #(.PIPE_LAT(PL), .KEY_LAT(KL), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .pipe_data(pipe_data), .pipe_key(pipe_key), .pipe_out(pipe_out),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_data(rsp_data)
`ifdef AES_PIPE_CTRL_STATS_EN
    , .stat_blocks(stat_blocks), .stat_rekeys(stat_rekeys)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, rot, acc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      acc = inv; rot = inv;
      for (int k = 0; k < 4; k++) begin
        rot = {rot[6:0], rot[7]};
        acc = acc ^ rot;
      end
      sbox[x] = acc ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // External pipeline: samples pipe_data/pipe_key, ciphertext appears PL edges later
  logic [127:0] pd_q [PL-1];
  logic [127:0] pk_q [PL-1];
  always @(posedge clk) begin
    pd_q[0] <= pipe_data;
    pk_q[0] <= pipe_key;
    for (int i = 1; i < PL-1; i++) begin
      pd_q[i] <= pd_q[i-1];
      pk_q[i] <= pk_q[i-1];
    end
    pipe_out <= aes_enc(pd_q[PL-2], pk_q[PL-2]);
  end

  // ---------------- reference model ----------------
  typedef struct { int due; logic src; logic [TW-1:0] tag; logic [127:0] ct; } exp_t;
  exp_t q [$];

  int          n_assert = 0, n_fail = 0;
  int          cyc = 0, m_acc = 0, m_hs_cyc = 0, m_load_left = 0, n_rsp = 0;
  bit          m_have_key, m_key_pending, m_last, auto_drop;
  logic [127:0] m_key, m_pdata;
  logic [31:0] m_blocks;
  logic [15:0] m_rekeys;
  logic          log_src [$];
  logic [TW-1:0] log_tag [$];
  logic [127:0]  log_data [$];
  int            log_cyc [$];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag, input bit ok);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s observed=budget_expired expected=event_within_budget", tag);
    end
  endtask

  task automatic reset_model();
    q.delete();
    m_have_key = 1'b0; m_key_pending = 1'b0; m_last = 1'b1; m_load_left = 0;
    m_key = '0; m_pdata = '0; m_blocks = 32'd0; m_rekeys = 16'd0;
  endtask

  // One clock: check outputs at the falling edge, then apply the rules at the rising edge
  task automatic step();
    logic exp_rv, kr, acc_en, in_run;
    logic [1:0] g;
    logic [127:0] d;
    exp_t e;
    @(negedge clk);
    exp_rv = (q.size() > 0) && (q[0].due == cyc);
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      log_src.push_back(rsp_src); log_tag.push_back(rsp_tag);
      log_data.push_back(rsp_data); log_cyc.push_back(cyc);
    end
    if (exp_rv) begin
      chk("rsp_src", 128'(rsp_src), 128'(q[0].src));
      chk("rsp_tag", 128'(rsp_tag), 128'(q[0].tag));
      chk("rsp_data", rsp_data, q[0].ct);
    end
    chk("pipe_data", pipe_data, m_pdata);
    chk("pipe_key", pipe_key, m_key);
`ifdef AES_PIPE_CTRL_STATS_EN
    chk("stat_blocks", 128'(stat_blocks), 128'(m_blocks));
    chk("stat_rekeys", 128'(stat_rekeys), 128'(m_rekeys));
`endif
    in_run = m_have_key && (m_load_left == 0) && !m_key_pending;
    acc_en = !rst && in_run && !key_valid;
    g = 2'b00;
    if (acc_en) begin
      if (req0_valid && req1_valid) g = m_last ? 2'b01 : 2'b10;
      else                          g = {req1_valid, req0_valid};
    end
    kr = !rst && (!m_have_key || (m_key_pending && q.size() == 0));
    chk("req0_ready", 128'(req0_ready), 128'(g[0]));
    chk("req1_ready", 128'(req1_ready), 128'(g[1]));
    chk("key_ready", 128'(key_ready), 128'(kr));
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      reset_model();
    end else begin
      if (exp_rv) void'(q.pop_front());
      if (m_load_left > 0) m_load_left--;
      if (key_valid && kr) begin
        m_key = key_in; m_have_key = 1'b1; m_key_pending = 1'b0; m_load_left = KL;
        m_rekeys++; m_hs_cyc = cyc; key_valid = 1'b0;
      end else if (in_run && key_valid) begin
        m_key_pending = 1'b1;
      end
      if (g != 2'b00) begin
        d = g[1] ? req1_data : req0_data;
        e.due = cyc + PL; e.src = g[1]; e.tag = g[1] ? req1_tag : req0_tag;
        e.ct = aes_enc(d, m_key);
        q.push_back(e);
        m_pdata = d; m_last = g[1]; m_blocks++; m_acc++;
        if (g[1]) begin
          req1_data = rnd128(); req1_tag = TW'($urandom);
          if (auto_drop) req1_valid = 1'b0;
        end else begin
          req0_data = rnd128(); req0_tag = TW'($urandom);
          if (auto_drop) req0_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_acc(input int n);
    int target, budget;
    target = m_acc + n; budget = 200;
    while (m_acc < target && budget > 0) begin step(); budget--; end
    tmo("accept_wait", m_acc >= target);
  endtask

  task automatic wait_key();
    int budget;
    budget = 200;
    while (key_valid && budget > 0) begin step(); budget--; end
    tmo("key_wait", !key_valid);
  endtask

  task automatic run_idle();
    int budget;
    budget = 4 * PL;
    while (q.size() > 0 && budget > 0) begin step(); budget--; end
    tmo("drain_wait", q.size() == 0);
    repeat (2) step();
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_valid = 1'b1;
    wait_key();
  endtask

  int idx0, nr0;

  initial begin
    build_sbox();
    reset_model();
    rst = 1'b1; auto_drop = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; key_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0; key_in = '0;
    repeat (2) step();
    rst = 1'b0;

    // Block before any key, then the FIPS-197 known-answer block
    auto_drop = 1'b1;
    req0_valid = 1'b1; req0_data = 128'h00112233445566778899aabbccddeeff; req0_tag = 4'd3;
    repeat (5) step();
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    wait_acc(1);
    run_idle();
    chk("kat_count", 128'(n_rsp), 128'(1));
    chk("kat_data", (log_data.size() > 0) ? log_data[0] : 'x, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("kat_src", (log_src.size() > 0) ? 128'(log_src[0]) : 'x, 128'(0));
    chk("kat_tag", (log_tag.size() > 0) ? 128'(log_tag[0]) : 'x, 128'(3));

    // Fresh reset, both requesters contending for 8 blocks
    rst = 1'b1; step(); rst = 1'b0;
    auto_drop = 1'b0;
    load_key(rnd128());
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    idx0 = log_src.size();
    run_idle();
    chk("rr_count", 128'(log_src.size() - idx0), 128'(8));
    for (int i = 0; i < 8 && idx0 + i < log_src.size(); i++) begin
      chk("rr_order", 128'(log_src[idx0+i]), 128'(i % 2));
      chk("rr_consecutive", 128'(log_cyc[idx0+i] - log_cyc[idx0]), 128'(i));
    end

    // Rekey with 5 blocks in flight
    nr0 = n_rsp;
    req0_valid = 1'b1;
    wait_acc(5);
    key_in = rnd128(); key_valid = 1'b1;
    wait_key();
    chk("drain_rsp_count", 128'(n_rsp - nr0), 128'(5));
    chk("drain_hs_gap", 128'(m_hs_cyc - log_cyc[log_cyc.size()-1]), 128'(2));
    repeat (KL + 6) step();
    req0_valid = 1'b0;
    run_idle();

    // Randomized traffic with occasional rekeys
    repeat (300) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = $urandom_range(0, 1) == 1;
      if (!key_valid && $urandom_range(0, 59) == 0) begin
        key_valid = 1'b1; key_in = rnd128();
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (key_valid) wait_key();
    repeat (KL + 2) step();
    run_idle();

    // Reset with 4 blocks in flight
    req0_valid = 1'b1;
    wait_acc(4);
    req0_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    nr0 = n_rsp;
    repeat (3 * PL) step();
    chk("rsp_after_rst", 128'(n_rsp - nr0), 128'(0));
    chk("nokey_key_ready", 128'(key_ready), 128'(1));
    chk("nokey_req0_ready", 128'(req0_ready), 128'(0));

    // Three blocks and two rekeys from reset
    auto_drop = 1'b1;
    load_key(rnd128());
    repeat (3) begin
      req0_valid = 1'b1;
      wait_acc(1);
    end
    load_key(rnd128());
    run_idle();
`ifdef AES_PIPE_CTRL_STATS_EN
    chk("stat_blocks_final", 128'(stat_blocks), 128'(3));
    chk("stat_rekeys_final", 128'(stat_rekeys), 128'(2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
